wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Write-back pipeline stage: the writer end of the register-file port that the decode stage reads from.
- Holds the MEM/WB pipeline register.
- Selects write-back data by `rf_wsel` and drives the RF write port (`wR`/`wD`/`we`).
- Provides same-cycle bypass of the pending write to the decode-stage read addresses.
- Counts retired instructions for debug.

Parameters:
- DATA_W, 32, datapath width.
- CNT_W, 32, width of retire counter.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- stall  input  1  hold MEM/WB register contents
- flush  input  1  insert bubble into MEM/WB register
- mem_valid  input  1  MEM stage holds a real instruction
- mem_pc  input  DATA_W  PC of MEM-stage instruction
- mem_pc4  input  DATA_W  PC+4 of MEM-stage instruction
- mem_alu_c  input  DATA_W  ALU result
- mem_ext  input  DATA_W  sign-extended immediate
- mem_wr  input  5  destination register index
- mem_rf_we  input  1  instruction writes RF
- mem_rf_wsel  input  2  write-back source select, `RF_WSEL_*` codes from defines.vh
- dram_rdo  input  DATA_W  DRAM read data; synchronous DRAM, valid in the WB cycle
- id_rR1  input  5  decode-stage read address 1
- id_rR2  input  5  decode-stage read address 2
- rf_wR  output  5  RF write address
- rf_wD  output  DATA_W  RF write data
- rf_we  output  1  RF write enable
- fwd1_hit  output  1  pending write matches id_rR1
- fwd2_hit  output  1  pending write matches id_rR2
- fwd_data  output  DATA_W  bypass value (equals rf_wD)
- wb_valid  output  1  WB stage holds a real instruction
- wb_pc  output  DATA_W  PC of WB instruction (debug)
- retire_cnt  output  CNT_W  instructions retired since reset

Behaviour:
- MEM/WB register fields: valid, pc, pc4, alu_c, ext, wr, rf_we, rf_wsel.
- Reset: when rst_n=0 at a rising edge, all register fields and retire_cnt clear to 0. Resulting outputs:
  - wb_valid=0, rf_we=0, rf_wR=0, wb_pc=0, fwd hits=0.
  - rf_wD=alu_c reg=0, because rf_wsel resets to `RF_WSEL_ALU`.
- Reset has priority over flush and stall. Reset mid-operation discards the held instruction; no RF write occurs in the reset cycle or the cycle after.
- Update priority per edge (rst_n=1): flush > stall > load.
  - flush=1: valid<=0, rf_we<=0; other fields don't-care, implementation clears them.
  - stall=1 and flush=0: all fields hold.
  - Otherwise: all fields load from mem_*. valid<=mem_valid.
- Latency: an instruction presented on mem_* at edge N drives the RF write during cycle N..N+1. The RF samples it at edge N+1.
- Write-data mux (combinational from register):
  - `RF_WSEL_ALU` -> alu_c.
  - `RF_WSEL_PC4` -> pc4.
  - `RF_WSEL_EXT` -> ext.
  - `RF_WSEL_RDO` -> dram_rdo (live input).
  - Any other code -> 0.
- rf_we = valid & rf_we_reg & (wr != 0). Writes to x0 are always suppressed.
- rf_wR = wr register. rf_wD = mux output. Both are driven even when rf_we=0.
- Stall with valid=1 keeps rf_we asserted every stalled cycle. Rewriting the same register with the same value is idempotent and permitted.
- fwdN_hit = rf_we & (wr == id_rRN). It is never asserted for address 0. Both hits may assert together when id_rR1==id_rR2.
- fwd_data = rf_wD.
- retire_cnt increments by 1 on each edge where valid=1 and stall=0 and rst_n=1. An instruction counts once, when it leaves WB. Wraps modulo 2^CNT_W (all-ones -> 0), no saturation.
- wb_valid = valid register; wb_pc = pc register.
- No combinational path from stall/flush to any output; all control outputs derive from the register and the id_rR*/dram_rdo inputs.

Test Plan:
- Reset: hold rst_n=0 two cycles with mem_valid=1, mem_rf_we=1 -> rf_we=0, wb_valid=0, retire_cnt=0, rf_wD=0; release -> first load appears next cycle.
- Mux sweep: mem_wr=5, mem_rf_we=1, alu_c=0x11, pc4=0x104, ext=0xFFFFFFF0, dram_rdo=0xDEADBEEF; step through the four wsel codes -> rf_wD 0x11, 0x104, 0xFFFFFFF0, 0xDEADBEEF; rf_wR=5, rf_we=1.
- x0 suppression: mem_wr=0, mem_rf_we=1, id_rR1=0 -> rf_we=0, fwd1_hit=0; retire_cnt still increments.
- Forwarding: wr=7 pending; id_rR1=7, id_rR2=7 -> both hits=1, fwd_data=rf_wD; id_rR2=8 -> fwd2_hit=0.
- Stall/flush: load wr=3, stall 3 cycles -> rf_we=1 held, retire_cnt unchanged; assert flush together with stall -> wb_valid=0 next cycle, retire_cnt +1 only for the non-stalled exit (0 here).
- Counter wrap: preload via 2^CNT_W-1 retirements (CNT_W=4 build: 15 valid cycles) -> retire_cnt=15; one more -> 0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, RF write port, same-cycle bypass to decode, retire counter.
// Latency: one edge from mem_* into WB. stall holds and flush bubbles the register; it never stalls upstream.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_pc,
    input  logic [DATA_W-1:0] mem_pc4,
    input  logic [DATA_W-1:0] mem_alu_c,
    input  logic [DATA_W-1:0] mem_ext,
    input  logic [4:0]        mem_wr,
    input  logic              mem_rf_we,
    input  logic [1:0]        mem_rf_wsel,
    input  logic [DATA_W-1:0] dram_rdo,
    input  logic [4:0]        id_rR1,
    input  logic [4:0]        id_rR2,
    output logic [4:0]        rf_wR,
    output logic [DATA_W-1:0] rf_wD,
    output logic              rf_we,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_pc,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam logic [1:0] RF_WSEL_ALU = 2'd0;
    localparam logic [1:0] RF_WSEL_PC4 = 2'd1;
    localparam logic [1:0] RF_WSEL_EXT = 2'd2;
    localparam logic [1:0] RF_WSEL_RDO = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] alu_c;
        logic [DATA_W-1:0] ext;
        logic [4:0]        wr;
        logic              rf_we;
        logic [1:0]        rf_wsel;
    } mem_wb_t;

    mem_wb_t mw_q;
    mem_wb_t mw_load;

    always_comb begin
        mw_load.valid   = mem_valid;
        mw_load.pc      = mem_pc;
        mw_load.pc4     = mem_pc4;
        mw_load.alu_c   = mem_alu_c;
        mw_load.ext     = mem_ext;
        mw_load.wr      = mem_wr;
        mw_load.rf_we   = mem_rf_we;
        mw_load.rf_wsel = mem_rf_wsel;
    end

    // Clearing the whole register on flush leaves rf_wsel at ALU, same as reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mw_q <= '0;
        end else if (flush) begin
            mw_q <= '0;
        end else if (!stall) begin
            mw_q <= mw_load;
        end
    end

    // An instruction retires on the edge it leaves WB, so stalled cycles don't count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (mw_q.valid && !stall) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

    always_comb begin
        rf_wD = '0;
        case (mw_q.rf_wsel)
            RF_WSEL_ALU: rf_wD = mw_q.alu_c;
            RF_WSEL_PC4: rf_wD = mw_q.pc4;
            RF_WSEL_EXT: rf_wD = mw_q.ext;
            RF_WSEL_RDO: rf_wD = dram_rdo;
            default:     rf_wD = '0;
        endcase
    end

    assign rf_wR    = mw_q.wr;
    assign rf_we    = mw_q.valid && mw_q.rf_we && (mw_q.wr != 5'd0);
    assign fwd1_hit = rf_we && (mw_q.wr == id_rR1);
    assign fwd2_hit = rf_we && (mw_q.wr == id_rR2);
    assign fwd_data = rf_wD;
    assign wb_valid = mw_q.valid;
    assign wb_pc    = mw_q.pc;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage built with CNT_W=4 so the retire counter wrap is reachable.
module tb_wb_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              flush;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_pc;
    logic [DATA_W-1:0] mem_pc4;
    logic [DATA_W-1:0] mem_alu_c;
    logic [DATA_W-1:0] mem_ext;
    logic [4:0]        mem_wr;
    logic              mem_rf_we;
    logic [1:0]        mem_rf_wsel;
    logic [DATA_W-1:0] dram_rdo;
    logic [4:0]        id_rR1;
    logic [4:0]        id_rR2;
    logic [4:0]        rf_wR;
    logic [DATA_W-1:0] rf_wD;
    logic              rf_we;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_pc;
    logic [CNT_W-1:0]  retire_cnt;

    int tests;
    int fails;

    wb_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_pc4(mem_pc4),
        .mem_alu_c(mem_alu_c), .mem_ext(mem_ext), .mem_wr(mem_wr),
        .mem_rf_we(mem_rf_we), .mem_rf_wsel(mem_rf_wsel), .dram_rdo(dram_rdo),
        .id_rR1(id_rR1), .id_rR2(id_rR2),
        .rf_wR(rf_wR), .rf_wD(rf_wD), .rf_we(rf_we),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        mem_valid = 1'b1; mem_rf_we = 1'b1; mem_wr = 5'd5; mem_rf_wsel = 2'd0;
        mem_pc = 32'h100; mem_pc4 = 32'h104; mem_alu_c = 32'h11;
        mem_ext = 32'hFFFF_FFF0; dram_rdo = 32'hDEAD_BEEF;
        id_rR1 = 5'd5; id_rR2 = 5'd9;

        // Reset held two cycles with a live instruction on mem_*
        tick(); tick();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_cnt", retire_cnt, 0);
        chk("rst_rf_wD", rf_wD, 0);
        chk("rst_rf_wR", rf_wR, 0);
        chk("rst_wb_pc", wb_pc, 0);
        chk("rst_fwd1", fwd1_hit, 0);

        // Mux sweep: ALU, PC4, EXT, RDO
        rst_n = 1'b1;
        tick();
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_pc", wb_pc, 32'h100);
        chk("ld_rf_wR", rf_wR, 5);
        chk("ld_rf_we", rf_we, 1);
        chk("mux_alu", rf_wD, 32'h11);
        chk("ld_fwd1", fwd1_hit, 1);
        chk("ld_fwd2", fwd2_hit, 0);
        chk("ld_cnt", retire_cnt, 0);
        mem_rf_wsel = 2'd1;
        tick();
        chk("mux_pc4", rf_wD, 32'h104);
        chk("cnt1", retire_cnt, 1);
        mem_rf_wsel = 2'd2;
        tick();
        chk("mux_ext", rf_wD, 32'hFFFF_FFF0);
        chk("cnt2", retire_cnt, 2);
        mem_rf_wsel = 2'd3;
        tick();
        chk("mux_rdo", rf_wD, 32'hDEAD_BEEF);
        chk("cnt3", retire_cnt, 3);
        dram_rdo = 32'h1234_5678;
        #1;
        chk("mux_rdo_live", rf_wD, 32'h1234_5678);
        chk("fwd_data_rdo", fwd_data, 32'h1234_5678);

        // Write to x0 is suppressed but still retires
        mem_wr = 5'd0; mem_rf_wsel = 2'd0; id_rR1 = 5'd0;
        tick();
        chk("x0_rf_we", rf_we, 0);
        chk("x0_fwd1", fwd1_hit, 0);
        chk("x0_wb_valid", wb_valid, 1);
        chk("x0_cnt", retire_cnt, 4);

        // Forwarding to both read ports
        mem_wr = 5'd7; mem_alu_c = 32'h77; id_rR1 = 5'd7; id_rR2 = 5'd7;
        tick();
        chk("fwd_both1", fwd1_hit, 1);
        chk("fwd_both2", fwd2_hit, 1);
        chk("fwd_data", fwd_data, 32'h77);
        chk("fwd_cnt", retire_cnt, 5);
        id_rR2 = 5'd8;
        #1;
        chk("fwd2_miss", fwd2_hit, 0);
        chk("fwd1_keep", fwd1_hit, 1);

        // Stall holds the register; mem_* changes must not leak in
        mem_wr = 5'd3; mem_alu_c = 32'h33; id_rR1 = 5'd3;
        tick();
        chk("st_ld_wR", rf_wR, 3);
        chk("st_ld_cnt", retire_cnt, 6);
        stall = 1'b1; mem_wr = 5'd9; mem_alu_c = 32'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_rf_we", rf_we, 1);
            chk("st_rf_wR", rf_wR, 3);
            chk("st_rf_wD", rf_wD, 32'h33);
            chk("st_cnt", retire_cnt, 6);
        end
        flush = 1'b1;
        tick();
        chk("fl_st_valid", wb_valid, 0);
        chk("fl_st_rf_we", rf_we, 0);
        chk("fl_st_fwd1", fwd1_hit, 0);
        chk("fl_st_cnt", retire_cnt, 6);
        chk("fl_st_wsel", rf_wD, 0);
        stall = 1'b0; flush = 1'b0; mem_valid = 1'b0;
        tick();
        chk("bubble_valid", wb_valid, 0);
        chk("bubble_cnt", retire_cnt, 6);

        // Flush without stall: the valid instruction leaves and counts
        mem_valid = 1'b1;
        tick();
        chk("fl_ld_valid", wb_valid, 1);
        flush = 1'b1;
        tick();
        chk("fl_valid", wb_valid, 0);
        chk("fl_cnt", retire_cnt, 7);
        flush = 1'b0;

        // Reset mid-operation, also beats flush and stall
        tick();
        chk("mid_valid_pre", wb_valid, 1);
        rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
        tick();
        chk("mid_rst_valid", wb_valid, 0);
        chk("mid_rst_rf_we", rf_we, 0);
        chk("mid_rst_cnt", retire_cnt, 0);
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0;

        // Counter wrap: 15 retirements then one more
        tick();
        chk("wrap_start", retire_cnt, 0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("wrap_step", retire_cnt, 64'(i));
        end
        tick();
        chk("wrap_zero", retire_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
